// File: rtl/univ_shift_pkg.sv
// Shared constants for the universal shift register.
package univ_shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/univ_shift_reg_cnt.sv
// Shift counter: counts shifts since last load/reset, saturates at WIDTH,
// raises full while saturated and pulses done once on reaching WIDTH.
module shift_cnt #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inc,
  input  logic                         clr,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         full,
  output logic                         done
);

  localparam int CW = $clog2(WIDTH+1);

  logic last;
  assign last = (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      full <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        cnt  <= '0;
        full <= 1'b0;
      end else if (inc && !full) begin
        // full gates further counting so done can only fire once per run
        cnt  <= cnt + CW'(1);
        full <= last;
        done <= last;
      end
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// optional rotate, with a saturating shift counter.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic                         rot,
  input  logic                         sin_r,
  input  logic                         sin_l,
  input  logic [WIDTH-1:0]             pin,
  output logic [WIDTH-1:0]             pout,
  output logic                         sout_r,
  output logic                         sout_l,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         full,
  output logic                         done
);

  logic [WIDTH-1:0] q, nxt;
  logic             inc, clr;

  always_comb begin
    nxt = q;
    inc = 1'b0;
    clr = 1'b0;
    case (mode_e'(mode))
      MODE_SHR: begin
        nxt = {(rot ? q[0] : sin_r), q[WIDTH-1:1]};
        inc = en;
      end
      MODE_SHL: begin
        nxt = {q[WIDTH-2:0], (rot ? q[WIDTH-1] : sin_l)};
        inc = en;
      end
      MODE_LOAD: begin
        nxt = pin;
        clr = en;
      end
      default: nxt = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= RST_VAL;
    else if (en) q <= nxt;
  end

  assign pout   = q;
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

  shift_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc),
    .clr  (clr),
    .cnt  (cnt),
    .full (full),
    .done (done)
  );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench: a WIDTH=4 and a WIDTH=8 instance with hand-computed vectors.
module tb_univ_shift_reg;

  localparam logic [1:0] HOLD = 2'b00, SHR = 2'b01, SHL = 2'b10, LOAD = 2'b11;

  logic clk, rst;

  logic       en4, rot4, sr4, sl4;
  logic [1:0] md4;
  logic [3:0] pin4, pout4;
  logic       sor4, sol4, full4, done4;
  logic [2:0] cnt4;

  logic       en8, rot8, sr8, sl8;
  logic [1:0] md8;
  logic [7:0] pin8, pout8;
  logic       sor8, sol8, full8, done8;
  logic [3:0] cnt8;

  int errs = 0;
  int checks = 0;

  univ_shift_reg #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .en(en4), .mode(md4), .rot(rot4), .sin_r(sr4), .sin_l(sl4),
    .pin(pin4), .pout(pout4), .sout_r(sor4), .sout_l(sol4), .cnt(cnt4), .full(full4), .done(done4)
  );

  univ_shift_reg #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .en(en8), .mode(md8), .rot(rot8), .sin_r(sr8), .sin_l(sl8),
    .pin(pin8), .pout(pout8), .sout_r(sor8), .sout_l(sol8), .cnt(cnt8), .full(full8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv4(input logic e, input logic [1:0] m, input logic r,
                      input logic sr, input logic sl, input logic [3:0] p);
    en4 = e; md4 = m; rot4 = r; sr4 = sr; sl4 = sl; pin4 = p;
  endtask

  task automatic drv8(input logic e, input logic [1:0] m, input logic r,
                      input logic sr, input logic sl, input logic [7:0] p);
    en8 = e; md8 = m; rot8 = r; sr8 = sr; sl8 = sl; pin8 = p;
  endtask

  initial begin
    rst = 1'b0;
    drv4(0, HOLD, 0, 0, 0, '0);
    drv8(0, HOLD, 0, 0, 0, '0);
    #2;
    // reset values before any clock edge
    chk("rst_pout4", pout4, 4'h0);
    chk("rst_cnt4",  cnt4,  0);
    chk("rst_full4", full4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_pout8", pout8, 8'h00);
    #6 rst = 1'b1;

    // right shift 1,0,1,1 into zeros
    drv4(1, SHR, 0, 1, 0, '0); tick();
    chk("shr1_pout", pout4, 4'b1000);
    sr4 = 0; tick();
    chk("shr2_pout", pout4, 4'b0100);
    sr4 = 1; tick();
    chk("shr3_cnt",  cnt4,  3);
    chk("shr3_done", done4, 0);
    chk("shr3_full", full4, 0);
    sr4 = 1; tick();
    chk("shr4_pout", pout4, 4'b1101);
    chk("shr4_cnt",  cnt4,  4);
    chk("shr4_full", full4, 1);
    chk("shr4_done", done4, 1);
    chk("shr4_sor",  sor4,  1);
    chk("shr4_sol",  sol4,  1);

    // load right after saturation: clears, no second done
    drv4(1, LOAD, 0, 0, 0, 4'hF); tick();
    chk("ld_pout", pout4, 4'hF);
    chk("ld_cnt",  cnt4,  0);
    chk("ld_full", full4, 0);
    chk("ld_done", done4, 0);

    // en toggling 1,0,1,0
    drv4(1, SHR, 0, 0, 0, '0); tick();
    chk("en1_pout", pout4, 4'b0111);
    en4 = 0; tick();
    chk("en0_pout", pout4, 4'b0111);
    chk("en0_cnt",  cnt4,  1);
    en4 = 1; tick();
    en4 = 0; tick();
    chk("en_pout", pout4, 4'b0011);
    chk("en_cnt",  cnt4,  2);

    // mode hold with en high
    drv4(1, HOLD, 0, 1, 1, 4'h9); tick();
    chk("hold_pout", pout4, 4'b0011);
    chk("hold_cnt",  cnt4,  2);
    chk("hold_done", done4, 0);

    // async reset mid-sequence (cnt=2), then 4 fresh shifts
    drv4(0, HOLD, 0, 0, 0, '0);
    #2 rst = 1'b0;
    #1;
    chk("arst_pout", pout4, 4'h0);
    chk("arst_cnt",  cnt4,  0);
    #2 rst = 1'b1;
    drv4(1, SHR, 0, 1, 0, '0);
    tick(); tick(); tick();
    chk("rs3_cnt",  cnt4,  3);
    chk("rs3_done", done4, 0);
    tick();
    chk("rs4_cnt",  cnt4,  4);
    chk("rs4_done", done4, 1);
    chk("rs4_pout", pout4, 4'hF);
    drv4(1, HOLD, 0, 0, 0, '0); tick();
    chk("rs5_done", done4, 0);
    chk("rs5_full", full4, 1);
    chk("rs5_cnt",  cnt4,  4);

    // left shift with sin_l
    drv4(1, LOAD, 0, 0, 0, 4'h0); tick();
    drv4(1, SHL, 0, 0, 1, '0); tick();
    chk("shl1_pout", pout4, 4'b0001);
    sl4 = 0; tick();
    chk("shl2_pout", pout4, 4'b0010);
    chk("shl2_cnt",  cnt4,  2);
    drv4(0, HOLD, 0, 0, 0, '0);

    // WIDTH=8: load A5, rotate left x3
    drv8(1, LOAD, 0, 0, 0, 8'hA5); tick();
    chk("a5_pout", pout8, 8'hA5);
    chk("a5_cnt",  cnt8,  0);
    drv8(1, SHL, 1, 0, 1, '0);
    tick(); tick(); tick();
    chk("rotl_pout", pout8, 8'h2D);
    chk("rotl_sol",  sol8,  0);
    chk("rotl_cnt",  cnt8,  3);

    // load 81, 9 right shifts of zero
    drv8(1, LOAD, 0, 0, 0, 8'h81); tick();
    chk("81_sor", sor8, 1);
    chk("81_cnt", cnt8, 0);
    drv8(1, SHR, 0, 0, 0, '0);
    for (int i = 1; i <= 7; i++) tick();
    chk("shr7_done", done8, 0);
    chk("shr7_pout", pout8, 8'h01);
    tick();
    chk("shr8_pout", pout8, 8'h00);
    chk("shr8_cnt",  cnt8,  8);
    chk("shr8_done", done8, 1);
    tick();
    chk("shr9_cnt",  cnt8,  8);
    chk("shr9_done", done8, 0);
    chk("shr9_full", full8, 1);

    // rotate right wraps bit 0 to MSB
    drv8(1, LOAD, 0, 0, 0, 8'h01); tick();
    drv8(1, SHR, 1, 0, 0, '0); tick();
    chk("rotr_pout", pout8, 8'h80);
    chk("rotr_sol",  sol8,  1);
    drv8(0, HOLD, 0, 0, 0, '0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, sets the register length in bits; legal range 2..64.
REQ-002 Parameter RST_VAL, default all-zeros, WIDTH bits, sets the register contents after reset.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-low reset.
REQ-005 Port en, input, 1, cycle enable; low means every state element holds.
REQ-006 Port mode, input, 2, operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 Port rot, input, 1, rotate select; when high, the shift fill bit comes from the opposite end instead of the serial input.
REQ-008 Port sin_r, input, 1, serial input entering the MSB on a right shift.
REQ-009 Port sin_l, input, 1, serial input entering the LSB on a left shift.
REQ-010 Port pin, input, WIDTH, parallel load data.
REQ-011 Port pout, output, WIDTH, current register contents.
REQ-012 Port sout_r, output, 1, register bit 0, the bit leaving on a right shift.
REQ-013 Port sout_l, output, 1, register bit WIDTH-1, the bit leaving on a left shift.
REQ-014 Port cnt, output, $clog2(WIDTH+1), number of shifts since the last load or reset, saturating at WIDTH.
REQ-015 Port full, output, 1, high while cnt equals WIDTH.
REQ-016 Port done, output, 1, single-cycle pulse in the cycle after the shift that brings cnt to WIDTH.

Function
REQ-017 On en=1 and mode=01, the register shall become {fill, reg[WIDTH-1:1]}, where fill = rot ? reg[0] : sin_r.
REQ-018 On en=1 and mode=10, the register shall become {reg[WIDTH-2:0], fill}, where fill = rot ? reg[WIDTH-1] : sin_l.
REQ-019 On en=1 and mode=11, the register shall load pin, clear cnt to 0 and clear full.
REQ-020 On mode=00 or en=0, the register, cnt and full shall hold; done shall be 0.
REQ-021 pout, sout_r and sout_l shall be driven directly from the register with no extra pipeline stage, so a serial bit entering at one end reaches the other end's output WIDTH edges later.
REQ-022 Each enabled shift shall increment cnt by 1; at WIDTH, cnt shall saturate and further shifts leave it at WIDTH.
REQ-023 done shall be registered: it is 1 only in the cycle immediately after the shift that moves cnt from WIDTH-1 to WIDTH, and it shall not re-fire while saturated.
REQ-024 rot shall not change cnt behaviour: rotations count as shifts.
REQ-025 cnt, full and done shall track shift count only; changes in the value of mode between shifts have no other effect on them.
REQ-026 A load and a shift cannot coincide because mode is exclusive; a load in the cycle after cnt reaches WIDTH shall clear cnt and full with no further done pulse.
REQ-027 All outputs shall be glitch-free registered values or direct register bits; there is no combinational path from inputs to outputs.

Reset
REQ-028 On rst low, asynchronously: register = RST_VAL, cnt = 0, full = 0, done = 0.
REQ-029 Reset asserted mid-shift-sequence shall abandon the sequence; after release, counting restarts from 0.
REQ-030 The first enabled edge after rst rises shall operate normally, with no dead cycle.

Structure
REQ-031 Mode encodings (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD) shall be constants in the shared package univ_shift_pkg.
REQ-032 The cnt/full/done logic shall be a sub-module, shift_cnt, parameterised by WIDTH, with inputs inc and clr.

Verification
REQ-033 Reset with WIDTH=4: hold rst low -> pout=0000, cnt=0, full=0, done=0 immediately, without waiting for a clock edge.
REQ-034 WIDTH=4 right shift of sin_r sequence 1,0,1,1 -> pout=1101; cnt=4; full=1; done high for exactly one cycle.
REQ-035 WIDTH=8, load 8'hA5, then 3 left rotates -> pout=8'h2D; sout_l=0; cnt=3.
REQ-036 WIDTH=8, load 8'h81, then 9 right shifts with sin_r=0 -> pout=8'h00 after the 8th shift; cnt stays at 8; a single done pulse.
REQ-037 Shift right with en toggling 1,0,1,0 -> the register and cnt advance only on en=1 edges (cnt=2 after 4 edges).
REQ-038 Assert rst after 2 of 4 shifts, then release and shift 4 more times -> cnt restarts from 0; done fires after the 4th post-reset shift.
